emu_run_ctrl: RTL and testbench
===============================

// Module: emu_run_ctrl
// PURPOSE
//   Host-side run controller for the emulation system: gates target execution via run_mode.
//   Counts target ticks and single-steps N ticks. Pauses on host request, step expiry or any of NTRIG masked triggers.
//   Sits beside EMU_SYSTEM in the host_clk domain.
//   Parametrised successor of the fixed 1-trigger, 64-bit count/step control logic.
// PARAMETERS
//   NTRIG   4   number of trigger inputs (1..32)
//   CNT_W   64  width of tick counter and breakpoint register
//   STEP_W  64  width of step down-counter
// PORTS
//   host_clk        in   1        host clock; all logic on posedge
//   host_rst        in   1        asynchronous active-high reset
//   tick            in   1        one target-cycle advance this host cycle
//   trig            in   NTRIG    trigger requests, sampled only when tick=1
//   trig_mask_write in   1        load trig_mask from trig_mask_wdata
//   trig_mask_wdata in   NTRIG    1 = trigger enabled
//   trig_latched    out  NTRIG    sticky record of enabled triggers that caused/joined a pause
//   trig_clear      in   NTRIG    write-1-to-clear for trig_latched
//   do_pause        in   1        host pause request (pulse)
//   do_resume       in   1        host resume request (pulse)
//   count           out  CNT_W    ticks executed while running
//   count_write     in   1        load count
//   count_wdata     in   CNT_W    count load value
//   step_write      in   1        load step counter (0 = stepping disabled)
//   step_wdata      in   STEP_W   step load value
//   step_trig       out  1        comb: step reaches 0 this cycle
//   run_mode        out  1        1 = target running
//   pause_cause     out  4        [0] host, [1] step, [2] trigger, [3] breakpoint
//   stopped         out  1        1-cycle pulse on RUN->PAUSED
// BEHAVIOUR
//   Reset: run_mode=1 (RUN), count=0, step=0, trig_mask=all 1, trig_latched=0, pause_cause=0, stopped=0, pend=0.
//   FSM RUN: stop_req = pend | do_pause | |(trig&mask) | step_trig | bp_hit.
//     If stop_req && tick: go PAUSED next cycle, run_mode=0, stopped=1.
//     pause_cause and trig_latched updated with every source active that cycle.
//   do_pause without tick: pend<=1 (sticky); pause taken on next tick. Triggers without tick are ignored.
//   FSM PAUSED: do_resume -> RUN next cycle; clears pend and pause_cause.
//     do_pause is ignored in PAUSED.
//     do_pause+do_resume in the same PAUSED cycle: resume wins, pause discarded.
//     do_resume in RUN is ignored.
//   count: count_write has priority; else +1 when run_mode&&tick (stopping tick is counted).
//     Wraps modulo 2^CNT_W.
//   step_next: step_write ? wdata : step==0 ? 0 : run_mode&&tick ? step-1 : step.
//     step_trig = step!=0 && step_next==0.
//     step_write with wdata=1 plus tick in RUN does not fire; the counter is loaded.
//   trig_latched: set wins over a same-cycle trig_clear on the same bit. Untouched by mask writes.
//   Mask/count/step writes are legal in either state and take effect next cycle.
//   host_rst mid-pause returns to RUN immediately (async), all state cleared.
// CONFIGURATION
//   EMU_RUN_CTRL_BREAKPOINT_EN defined: adds inputs bp_write(1) and bp_wdata(CNT_W).
//     Adds registers bp (reset 0) and bp_valid (reset 0). bp_write loads bp and sets bp_valid.
//     bp_hit = bp_valid && run_mode && tick && count+1==bp, compared in CNT_W bits with wrap.
//     bp_valid clears when bp_hit pauses.
//   Not defined: no bp ports, bp_hit=0, pause_cause[3] is constant 0.
// TESTING
//   Reset, tick every cycle, 10 cycles -> run_mode=1, count=10, pause_cause=0.
//   step_write 5, tick every cycle -> step_trig on 5th tick; run_mode=0 the next cycle.
//     count=+5; pause_cause=4'b0010; stopped pulses once.
//   do_pause with tick=0 for 3 cycles, then tick=1 -> pause on that tick; pause_cause=4'b0001.
//     Then do_resume -> run_mode=1 next cycle, pause_cause=0.
//   mask=4'b0101; trig=4'b0010 on tick -> no pause. trig=4'b0110 on tick -> pause.
//     trig_latched=4'b0100. trig_clear=4'b0100 -> 0.
//   PAUSED, do_pause&do_resume same cycle -> RUN; 5 more ticks with no pause.
//     count_write 2^CNT_W-1 then 1 tick -> count=0.
//   BREAKPOINT_EN: bp_write 20 from count=0, ticking -> pause with count=20, pause_cause[3]=1.
//     bp_valid=0; after resume, no re-hit.

Source files
------------

// File: rtl/emu_run_ctrl.sv
// Host-side run controller: gates target execution, counts ticks, single-steps and pauses on host/step/trigger.
// Optional breakpoint comparator is enabled by defining EMU_RUN_CTRL_BREAKPOINT_EN.
module emu_run_ctrl #(
    parameter int NTRIG  = 4,
    parameter int CNT_W  = 64,
    parameter int STEP_W = 64
) (
    input  logic              host_clk,
    input  logic              host_rst,
    input  logic              tick,
    input  logic [NTRIG-1:0]  trig,
    input  logic              trig_mask_write,
    input  logic [NTRIG-1:0]  trig_mask_wdata,
    output logic [NTRIG-1:0]  trig_latched,
    input  logic [NTRIG-1:0]  trig_clear,
    input  logic              do_pause,
    input  logic              do_resume,
    output logic [CNT_W-1:0]  count,
    input  logic              count_write,
    input  logic [CNT_W-1:0]  count_wdata,
    input  logic              step_write,
    input  logic [STEP_W-1:0] step_wdata,
    output logic              step_trig,
    output logic              run_mode,
    output logic [3:0]        pause_cause,
    output logic              stopped
`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
    ,
    input  logic              bp_write,
    input  logic [CNT_W-1:0]  bp_wdata
`endif
);

    typedef enum logic {S_RUN, S_PAUSED} state_t;

    state_t            state, next_state;
    logic [NTRIG-1:0]  trig_mask;
    logic [NTRIG-1:0]  trig_en;
    logic [STEP_W-1:0] step, step_next;
    logic              pend;
    logic              trig_any;
    logic              host_req;
    logic              bp_hit;
    logic              stop_req;
    logic              take_pause;
    logic              take_resume;

    assign run_mode = (state == S_RUN);
    assign trig_en  = trig & trig_mask;
    assign trig_any = |trig_en;
    assign host_req = pend | do_pause;

    always_comb begin
        step_next = step;
        if (step_write)
            step_next = step_wdata;
        else if (step == '0)
            step_next = '0;
        else if (run_mode && tick)
            step_next = step - STEP_W'(1);
    end

    assign step_trig = (step != '0) && (step_next == '0);

`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
    logic [CNT_W-1:0] bp;
    logic             bp_valid;
    logic [CNT_W-1:0] count_inc;

    // Compare against the value count takes after this tick, so the pause lands with count == bp.
    assign count_inc = count + CNT_W'(1);
    assign bp_hit    = bp_valid && run_mode && tick && (count_inc == bp);

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            bp       <= '0;
            bp_valid <= 1'b0;
        end else if (bp_write) begin
            bp       <= bp_wdata;
            bp_valid <= 1'b1;
        end else if (bp_hit && take_pause) begin
            bp_valid <= 1'b0;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    assign stop_req = host_req | trig_any | step_trig | bp_hit;

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst)
            state <= S_RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        take_pause  = 1'b0;
        take_resume = 1'b0;
        case (state)
            S_RUN: begin
                if (stop_req && tick) begin
                    next_state = S_PAUSED;
                    take_pause = 1'b1;
                end
            end
            S_PAUSED: begin
                if (do_resume) begin
                    next_state  = S_RUN;
                    take_resume = 1'b1;
                end
            end
            default: next_state = S_RUN;
        endcase
    end

    // A host pause seen between ticks is held until the next tick can honour it.
    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst)
            pend <= 1'b0;
        else if (take_resume || take_pause)
            pend <= 1'b0;
        else if (run_mode && do_pause && !tick)
            pend <= 1'b1;
    end

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            pause_cause  <= 4'b0000;
            stopped      <= 1'b0;
            trig_latched <= '0;
            trig_mask    <= '1;
        end else begin
            stopped <= take_pause;
            if (take_pause)
                pause_cause <= {bp_hit, trig_any, step_trig, host_req};
            else if (take_resume)
                pause_cause <= 4'b0000;
            trig_latched <= (trig_latched & ~trig_clear) | (take_pause ? trig_en : '0);
            if (trig_mask_write)
                trig_mask <= trig_mask_wdata;
        end
    end

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            count <= '0;
            step  <= '0;
        end else begin
            step <= step_next;
            if (count_write)
                count <= count_wdata;
            else if (run_mode && tick)
                count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed bench for emu_run_ctrl with a reference model feeding an expected-result queue.
// Define EMU_RUN_CTRL_BREAKPOINT_EN to also exercise the breakpoint comparator.
module tb_emu_run_ctrl;

    localparam int NTRIG  = 4;
    localparam int CNT_W  = 64;
    localparam int STEP_W = 64;

    logic              host_clk = 1'b0;
    logic              host_rst;
    logic              tick;
    logic [NTRIG-1:0]  trig;
    logic              trig_mask_write;
    logic [NTRIG-1:0]  trig_mask_wdata;
    logic [NTRIG-1:0]  trig_latched;
    logic [NTRIG-1:0]  trig_clear;
    logic              do_pause;
    logic              do_resume;
    logic [CNT_W-1:0]  count;
    logic              count_write;
    logic [CNT_W-1:0]  count_wdata;
    logic              step_write;
    logic [STEP_W-1:0] step_wdata;
    logic              step_trig;
    logic              run_mode;
    logic [3:0]        pause_cause;
    logic              stopped;
`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
    logic              bp_write;
    logic [CNT_W-1:0]  bp_wdata;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic             run;
        logic [CNT_W-1:0] cnt;
        logic [3:0]       cause;
        logic             stp;
        logic [NTRIG-1:0] latched;
    } expect_t;

    expect_t exp_q[$];

    // Reference model state
    logic              m_run;
    logic [CNT_W-1:0]  m_count;
    logic [STEP_W-1:0] m_step;
    logic [NTRIG-1:0]  m_mask;
    logic [NTRIG-1:0]  m_latched;
    logic [3:0]        m_cause;
    logic              m_pend;
    logic              m_stopped;
    logic [CNT_W-1:0]  m_bp;
    logic              m_bp_valid;

    emu_run_ctrl #(.NTRIG(NTRIG), .CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .host_clk        (host_clk),
        .host_rst        (host_rst),
        .tick            (tick),
        .trig            (trig),
        .trig_mask_write (trig_mask_write),
        .trig_mask_wdata (trig_mask_wdata),
        .trig_latched    (trig_latched),
        .trig_clear      (trig_clear),
        .do_pause        (do_pause),
        .do_resume       (do_resume),
        .count           (count),
        .count_write     (count_write),
        .count_wdata     (count_wdata),
        .step_write      (step_write),
        .step_wdata      (step_wdata),
        .step_trig       (step_trig),
        .run_mode        (run_mode),
        .pause_cause     (pause_cause),
        .stopped         (stopped)
`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
        ,
        .bp_write        (bp_write),
        .bp_wdata        (bp_wdata)
`endif
    );

    always #5 host_clk = ~host_clk;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        tick            = 1'b0;
        trig            = '0;
        trig_mask_write = 1'b0;
        trig_mask_wdata = '0;
        trig_clear      = '0;
        do_pause        = 1'b0;
        do_resume       = 1'b0;
        count_write     = 1'b0;
        count_wdata     = '0;
        step_write      = 1'b0;
        step_wdata      = '0;
`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
        bp_write        = 1'b0;
        bp_wdata        = '0;
`endif
    endtask

    task automatic model_reset();
        m_run      = 1'b1;
        m_count    = '0;
        m_step     = '0;
        m_mask     = '1;
        m_latched  = '0;
        m_cause    = 4'b0000;
        m_pend     = 1'b0;
        m_stopped  = 1'b0;
        m_bp       = '0;
        m_bp_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_output();
        expect_t e;
        if (exp_q.size() == 0) begin
            compare("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        compare("run_mode", 64'(run_mode), 64'(e.run));
        compare("count", count, e.cnt);
        compare("pause_cause", 64'(pause_cause), 64'(e.cause));
        compare("stopped", 64'(stopped), 64'(e.stp));
        compare("trig_latched", 64'(trig_latched), 64'(e.latched));
    endtask

    // Model one host cycle with the inputs currently driven, queue the result, clock, then check.
    task automatic apply_stimulus(input logic tk);
        logic [STEP_W-1:0] s_next;
        logic              s_trig, bp_h, host, tany, stop, bpw;
        logic [CNT_W-1:0]  bpd;
        logic [NTRIG-1:0]  set;
        expect_t           e;
        tick = tk;
        bpw = 1'b0;
        bpd = '0;
`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
        bpw = bp_write;
        bpd = bp_wdata;
`endif
        #1;
        s_next = step_write ? step_wdata : (m_step == 0) ? '0 : (m_run && tick) ? m_step - 1 : m_step;
        s_trig = (m_step != 0) && (s_next == 0);
        bp_h   = m_bp_valid && m_run && tick && ((m_count + 1) == m_bp);
        host   = m_pend || do_pause;
        tany   = |(trig & m_mask);
        stop   = m_run && tick && (host || tany || s_trig || bp_h);
        compare("step_trig", 64'(step_trig), 64'(s_trig));

        set = '0;
        if (count_write)          m_count = count_wdata;
        else if (m_run && tick)   m_count = m_count + 1;
        m_step = s_next;
        if (m_run) begin
            if (stop) begin
                m_run   = 1'b0;
                m_cause = {bp_h, tany, s_trig, host};
                set     = trig & m_mask;
                m_pend  = 1'b0;
            end else if (do_pause && !tick) begin
                m_pend = 1'b1;
            end
        end else if (do_resume) begin
            m_run   = 1'b1;
            m_cause = 4'b0000;
            m_pend  = 1'b0;
        end
        m_latched = (m_latched & ~trig_clear) | set;
        if (trig_mask_write) m_mask = trig_mask_wdata;
        if (bpw) begin
            m_bp       = bpd;
            m_bp_valid = 1'b1;
        end else if (bp_h && stop) begin
            m_bp_valid = 1'b0;
        end
        m_stopped = stop;

        e.run = m_run; e.cnt = m_count; e.cause = m_cause; e.stp = m_stopped; e.latched = m_latched;
        exp_q.push_back(e);
        @(posedge host_clk);
        #1;
        clear_inputs();
        check_output();
    endtask

    task automatic do_reset();
        clear_inputs();
        host_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge host_clk);
        @(negedge host_clk);
        host_rst = 1'b0;
        @(posedge host_clk);
        #1;
    endtask

    initial begin
        do_reset();
        compare("reset_run_mode", 64'(run_mode), 64'd1);
        compare("reset_count", count, 64'd0);
        compare("reset_cause", 64'(pause_cause), 64'd0);
        compare("reset_stopped", 64'(stopped), 64'd0);
        compare("reset_latched", 64'(trig_latched), 64'd0);

        // Free run for 10 ticks
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1);
        compare("run10_count", count, 64'd10);
        compare("run10_run_mode", 64'(run_mode), 64'd1);
        compare("run10_cause", 64'(pause_cause), 64'd0);

        // Step 5 ticks
        step_write = 1'b1; step_wdata = 64'd5;
        apply_stimulus(1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
        compare("step_run_mode", 64'(run_mode), 64'd0);
        compare("step_count", count, 64'd15);
        compare("step_cause", 64'(pause_cause), 64'b0010);
        compare("step_stopped", 64'(stopped), 64'd1);
        apply_stimulus(1'b1);
        compare("step_stopped_once", 64'(stopped), 64'd0);
        compare("paused_count_held", count, 64'd15);

        do_resume = 1'b1;
        apply_stimulus(1'b0);
        compare("resume1_run_mode", 64'(run_mode), 64'd1);

        // Host pause between ticks is deferred to the next tick
        for (int i = 0; i < 3; i++) begin
            do_pause = 1'b1;
            apply_stimulus(1'b0);
            compare("pend_still_running", 64'(run_mode), 64'd1);
        end
        apply_stimulus(1'b1);
        compare("host_run_mode", 64'(run_mode), 64'd0);
        compare("host_cause", 64'(pause_cause), 64'b0001);
        compare("host_count", count, 64'd16);
        do_resume = 1'b1;
        apply_stimulus(1'b0);
        compare("resume2_run_mode", 64'(run_mode), 64'd1);
        compare("resume2_cause", 64'(pause_cause), 64'd0);

        // Masked triggers
        trig_mask_write = 1'b1; trig_mask_wdata = 4'b0101;
        apply_stimulus(1'b0);
        trig = 4'b0010;
        apply_stimulus(1'b1);
        compare("masked_trig_run", 64'(run_mode), 64'd1);
        trig = 4'b0100;
        apply_stimulus(1'b0);
        compare("trig_no_tick_run", 64'(run_mode), 64'd1);
        trig = 4'b0110;
        apply_stimulus(1'b1);
        compare("trig_run_mode", 64'(run_mode), 64'd0);
        compare("trig_latched", 64'(trig_latched), 64'b0100);
        compare("trig_cause", 64'(pause_cause), 64'b0100);
        trig_clear = 4'b0100;
        apply_stimulus(1'b0);
        compare("trig_cleared", 64'(trig_latched), 64'd0);

        // Pause and resume together while paused: resume wins
        do_pause = 1'b1; do_resume = 1'b1;
        apply_stimulus(1'b0);
        compare("both_run_mode", 64'(run_mode), 64'd1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
        compare("both_no_pause", 64'(run_mode), 64'd1);
        compare("both_count", count, 64'd23);

        // Count wrap
        count_write = 1'b1; count_wdata = '1;
        apply_stimulus(1'b0);
        compare("count_loaded", count, 64'hFFFF_FFFF_FFFF_FFFF);
        apply_stimulus(1'b1);
        compare("count_wrap", count, 64'd0);

        // Step load of 1 coinciding with a tick only loads
        step_write = 1'b1; step_wdata = 64'd1;
        apply_stimulus(1'b1);
        compare("step1_load_run", 64'(run_mode), 64'd1);
        apply_stimulus(1'b1);
        compare("step1_fire_run", 64'(run_mode), 64'd0);

        // Asynchronous reset in the middle of a pause
        #2 host_rst = 1'b1;
        #1;
        compare("async_rst_run", 64'(run_mode), 64'd1);
        compare("async_rst_count", count, 64'd0);
        compare("async_rst_cause", 64'(pause_cause), 64'd0);
        do_reset();

`ifdef EMU_RUN_CTRL_BREAKPOINT_EN
        bp_write = 1'b1; bp_wdata = 64'd20;
        apply_stimulus(1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1);
        compare("bp_run_mode", 64'(run_mode), 64'd0);
        compare("bp_count", count, 64'd20);
        compare("bp_cause3", 64'(pause_cause[3]), 64'd1);
        do_resume = 1'b1;
        apply_stimulus(1'b0);
        for (int i = 0; i < 25; i++) apply_stimulus(1'b1);
        compare("bp_no_rehit", 64'(run_mode), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
